// File: rtl/ram_dump_reader.sv
// ram_dump_reader: streams a contiguous RAM window out as a byte stream.
// Reads are issued on the RAM secondary read port, the returned bytes go
// through a small prefetch FIFO and leave on a valid/ready stream.
// Optional feature macro: DUMP_CHECKSUM_EN appends an XOR checksum byte
// (state CSUM) after the last data byte and moves out_last onto it.
//
// Stream handshake: out_valid/out_data/out_last are offered by the block;
// a byte transfers on a rising ph1 edge where out_valid & out_ready.  Once
// out_valid is high it stays high with data and last unchanged until the
// transfer happens.  out_last is only meaningful while out_valid is high.
module ram_dump_reader #(
  parameter int AW         = 12,
  parameter int FIFO_DEPTH = 2    // 2 or 4 entries
) (
  input  logic          ph1,
  input  logic          resetb,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [2:0]    dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
`ifdef DUMP_CHECKSUM_EN
    ,
    S_CSUM  = 3'd4
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rd_left_q, rd_left_d;
  logic [AW-1:0] tx_left_q, tx_left_d;
  logic          inflight_q, inflight_d;   // a read was issued last cycle
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic data_valid;
  logic data_xfer;
  logic push;
  logic pop;
  logic room;

  // Control and pointer registers with asynchronous abort.
  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rd_left_q  <= '0;
      tx_left_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      tx_left_q  <= tx_left_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge ph1) begin
    fifo_q <= fifo_d;
  end

  // Next-state, read issue, FIFO bookkeeping and stream head selection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    tx_left_d  = tx_left_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;
    mem_re     = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    data_valid = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // Head: oldest buffered byte, else the byte returning from RAM this
    // cycle goes straight out so a streaming dump costs no extra latency.
    if (count_q != '0) begin
      data_valid = 1'b1;
      out_data   = fifo_q[rd_ptr_q];
    end else if (inflight_q) begin
      data_valid = 1'b1;
      out_data   = mem_rdata;
    end
    out_valid = data_valid;
    out_last  = data_valid && !CSUM_ON && (tx_left_q == AW'(1));
    data_xfer = data_valid && out_ready;

`ifdef DUMP_CHECKSUM_EN
    if (state_q == S_CSUM) begin
      out_valid = 1'b1;
      out_data  = csum_q;
      out_last  = 1'b1;
    end
    if (data_xfer) csum_d = csum_q ^ out_data;
`endif

    // Returned byte is buffered unless it bypassed straight out.
    if (inflight_q && !(count_q == '0 && out_ready)) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      push             = 1'b1;
    end
    if (data_xfer && count_q != '0) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      pop      = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (data_xfer) tx_left_d = tx_left_q - 1'b1;

    // A read is only issued when its byte is guaranteed a FIFO slot.
    room = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
    if (state_q == S_FETCH && rd_left_q != '0 && room) begin
      mem_re     = 1'b1;
      addr_d     = addr_q + 1'b1;
      rd_left_d  = rd_left_q - 1'b1;
      inflight_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = '0;
`endif
          if (length != '0) begin
            addr_d    = start_addr;
            rd_left_d = length;
            tx_left_d = length;
            state_d   = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (rd_left_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef DUMP_CHECKSUM_EN
        if (tx_left_d == '0) state_d = S_CSUM;
`else
        if (tx_left_d == '0) state_d = S_DONE;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: RAM model on the read port, expected stream
// built from the RAM array contents, monitor on the falling edge.
module tb_ram_dump_reader;

  localparam int AW    = 12;
  localparam int DEPTH = 2;
  localparam int MEMSZ = 1 << AW;
`ifdef DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          ph1 = 1'b0;
  logic          resetb;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [2:0]    dbg_state;

  logic [7:0]    ram [MEMSZ];
  logic [8:0]    exp_q[$];        // {last, data}
  logic [AW-1:0] exp_addr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt, acc_cnt, done_cnt, done_cyc, last_acc_cyc;
  int first_re_cyc, first_valid_cyc;
  bit mon_en = 1'b0;
  bit held = 1'b0;
  logic [8:0] held_val;

  ram_dump_reader #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .ph1(ph1), .resetb(resetb), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // clock / reset-independent infrastructure
  always #5 ph1 = ~ph1;
  always @(posedge ph1) cyc <= cyc + 1;

  // synchronous RAM: data one cycle after the strobe, garbage otherwise
  always @(posedge ph1) mem_rdata <= mem_re ? ram[mem_addr] : 8'($urandom);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic ready_at(input int mode, input int n);
    logic [3:0] pat;
    pat = 4'b1001;                       // 1,0,0,1 repeating
    case (mode)
      0:       return 1'b1;
      1:       return pat[2'(n % 4)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill_exp(input int sa, input int len);
    logic [7:0] x, b;
    exp_q.delete();
    exp_addr_q.delete();
    x = '0;
    for (int i = 0; i < len; i++) begin
      b = ram[(sa + i) % MEMSZ];
      x ^= b;
      exp_addr_q.push_back(AW'((sa + i) % MEMSZ));
      exp_q.push_back({(i == len - 1) && !CSUM_ON, b});
    end
    if (CSUM_ON && len != 0) exp_q.push_back({1'b1, x});
    rd_cnt = 0; acc_cnt = 0;
    first_re_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_re"},    mem_re, 0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"},  out_last, 0);
    check({tag, "_data"},  out_data, 0);
  endtask

  // scoreboard / protocol monitor
  always @(negedge ph1) begin
    if (!resetb) begin
      held = 1'b0;
    end else if (mon_en) begin
      if (held) check("hold_stable", {out_valid, out_last, out_data}, {1'b1, held_val});
      if (mem_re) begin
        check("re_room", int'((rd_cnt - acc_cnt) < DEPTH), 1);
        check("re_extra", int'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
        rd_cnt++;
        if (first_re_cyc < 0) first_re_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        check("byte_extra", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("byte", {out_last, out_data}, exp_q.pop_front());
        acc_cnt++;
        if (out_last) last_acc_cyc = cyc;
      end
      held = out_valid && !out_ready;
      held_val = {out_last, out_data};
      if (done) begin
        check("done_busy", busy, 1);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // driver: call at posedge+1, returns at posedge+1
  task automatic run_dump(input int sa, input int len, input int mode,
                          input bit poke, input bit chk_lat);
    int k0, dc0, n;
    fill_exp(sa, len);
    dc0 = done_cnt;
    k0 = cyc;
    start = 1'b1; start_addr = AW'(sa); length = AW'(len);
    out_ready = ready_at(mode, 0);
    @(negedge ph1);
    check("idle_busy", busy, 0);
    @(posedge ph1); #1;
    start = 1'b0; start_addr = AW'($urandom); length = AW'($urandom);
    n = 1;
    while (done_cnt == dc0 && n < 3000) begin
      start = poke && (n == 3);
      if (start) begin
        start_addr = AW'(sa + 100);
        length     = AW'(len + 5);
      end
      out_ready = ready_at(mode, n);
      @(negedge ph1);
      if (n == 1) check("busy_after_start", busy, 1);
      @(posedge ph1); #1;
      n++;
    end
    start = 1'b0;
    check("timeout", int'(done_cnt != dc0), 1);
    check("exp_empty", exp_q.size(), 0);
    check("addr_empty", exp_addr_q.size(), 0);
    if (len == 0) begin
      check("len0_done", done_cyc, k0 + 1);
      check("len0_re", first_re_cyc, -1);
      check("len0_valid", first_valid_cyc, -1);
    end else begin
      check("done_lat", done_cyc, last_acc_cyc + 1);
    end
    if (chk_lat) begin
      check("lat_re", first_re_cyc, k0 + 1);
      check("lat_valid", first_valid_cyc, k0 + 2);
    end
    @(negedge ph1);
    check("busy_end", busy, 0);
    check("done_low", done, 0);
    check("done_once", done_cnt, dc0 + 1);
    @(posedge ph1); #1;
  endtask

  initial begin
    int n, sa, len;
    for (int i = 0; i < MEMSZ; i++) ram[i] = 8'($urandom);
    done_cnt = 0;
    resetb = 1'b0; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b0;
    #3;
    check_zero_outputs("reset");
    @(posedge ph1); @(posedge ph1); #1;
    resetb = 1'b1;
    mon_en = 1'b1;
    @(posedge ph1); #1;

    // two-byte dump at full rate
    ram[169] = 8'hAA; ram[170] = 8'h55;
    run_dump(169, 2, 0, 1'b0, 1'b1);

    // empty dump
    run_dump(50, 0, 0, 1'b0, 1'b0);

    // incrementing pattern under 1,0,0,1 backpressure
    for (int i = 0; i < 16; i++) ram[32 + i] = 8'(i);
    run_dump(32, 16, 1, 1'b0, 1'b0);

    // window crossing the top of the address space
    run_dump(12'hFFE, 4, 0, 1'b0, 1'b0);
    run_dump(12'hFFE, 4, 1, 1'b0, 1'b0);

    // abort after three bytes of a ten-byte dump
    fill_exp(12'h300, 10);
    start = 1'b1; start_addr = 12'h300; length = 10; out_ready = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0;
    n = 0;
    while (acc_cnt < 3 && n < 100) begin
      @(negedge ph1); #1;
      n++;
    end
    check("mid_reach", acc_cnt, 3);
    #1 resetb = 1'b0;
    #1 check_zero_outputs("abort");
    @(posedge ph1); #1;
    resetb = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge ph1); #1;
    run_dump(12'h700, 2, 0, 1'b0, 1'b1);

    // start while busy must be ignored
    run_dump(12'h500, 10, 0, 1'b1, 1'b0);
    run_dump(12'h540, 10, 2, 1'b1, 1'b0);

    // random windows and backpressure
    for (int t = 0; t < 8; t++) begin
      sa  = $urandom_range(0, MEMSZ - 1);
      len = $urandom_range(1, 24);
      run_dump(sa, len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
